mem_stage_access: RTL

MEM-stage consumer of the EX/MEM pipeline register. It takes the registered EX/MEM outputs (ALU result, store data, destination register, instruction, control bits), runs each load or store through a request/acknowledge handshake to data memory, and stalls upstream until the access completes. It then drives the MEM/WB register outputs. Non-memory instructions pass straight through with one-cycle latency.

---
 rtl/mem_stage_access.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_access.sv
// MEM stage: runs loads/stores through a req/ack memory handshake, stalls upstream while busy, feeds MEM/WB; 1-cycle pass-through.
// Optional MEM_ALIGN_CHECK_EN: misaligned memory ops issue no request and flag errOut.
module mem_stage_access #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        validIn,
  input  logic [31:0] ALUResultIn,
  input  logic [31:0] storeDataIn,
  input  logic [4:0]  writeRegIn,
  input  logic [31:0] instrIn,
  input  logic        WBIn,
  input  logic        memReadIn,
  input  logic        memWriteIn,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memAck,
  output logic        stall,
  output logic        validOut,
  output logic        WBOut,
  output logic [31:0] ALUResultOut,
  output logic [31:0] readDataOut,
  output logic [31:0] instrOut,
  output logic [4:0]  writeRegOut,
  output logic        errOut
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] LP_LAST = 8'(MAX_WAIT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [7:0]  r_wait_cnt;
  logic [31:0] r_alu;
  logic [31:0] r_instr;
  logic [4:0]  r_wreg;
  logic        r_wb;
  logic        r_is_load;

  logic w_mem_op;
  logic w_misaligned;
  logic w_issue;
  logic w_timeout;

  assign w_mem_op  = validIn & (memReadIn | memWriteIn);
`ifdef MEM_ALIGN_CHECK_EN
  assign w_misaligned = (ALUResultIn[1:0] != 2'b00);
`else
  assign w_misaligned = 1'b0;
`endif
  assign w_issue   = w_mem_op & ~w_misaligned;
  assign w_timeout = (r_wait_cnt == LP_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_issue) w_next_state = S_WAIT;
      S_WAIT: if (memAck || w_timeout) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Release upstream on the ack or timeout cycle so the next op lands in IDLE.
  always_comb begin
    stall = 1'b0;
    case (r_state)
      S_IDLE: stall = w_issue;
      S_WAIT: stall = ~(memAck | w_timeout);
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt   <= 8'd0;
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= 32'd0;
      memWData     <= 32'd0;
      errOut       <= 1'b0;
      r_alu        <= 32'd0;
      r_instr      <= 32'd0;
      r_wreg       <= 5'd0;
      r_wb         <= 1'b0;
      r_is_load    <= 1'b0;
      validOut     <= 1'b0;
      WBOut        <= 1'b0;
      ALUResultOut <= 32'd0;
      readDataOut  <= 32'd0;
      instrOut     <= 32'd0;
      writeRegOut  <= 5'd0;
    end else begin
      errOut       <= 1'b0;
      validOut     <= 1'b0;
      WBOut        <= 1'b0;
      ALUResultOut <= 32'd0;
      readDataOut  <= 32'd0;
      instrOut     <= 32'd0;
      writeRegOut  <= 5'd0;
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            memReq     <= 1'b1;
            memWe      <= memWriteIn;
            memAddr    <= {ALUResultIn[31:2], 2'b00};
            memWData   <= storeDataIn;
            r_wait_cnt <= 8'd0;
            r_alu      <= ALUResultIn;
            r_instr    <= instrIn;
            r_wreg     <= writeRegIn;
            r_wb       <= WBIn;
            r_is_load  <= memReadIn & ~memWriteIn;  // store wins when both set
          end else if (w_mem_op) begin
            errOut <= 1'b1;
          end else if (validIn) begin
            validOut     <= 1'b1;
            WBOut        <= WBIn;
            ALUResultOut <= ALUResultIn;
            instrOut     <= instrIn;
            writeRegOut  <= writeRegIn;
          end
        end
        S_WAIT: begin
          if (memAck) begin
            memReq       <= 1'b0;
            validOut     <= 1'b1;
            WBOut        <= r_wb;
            ALUResultOut <= r_alu;
            readDataOut  <= r_is_load ? memRData : 32'd0;
            instrOut     <= r_instr;
            writeRegOut  <= r_wreg;
          end else if (w_timeout) begin
            memReq <= 1'b0;
            errOut <= 1'b1;
          end else begin
            r_wait_cnt <= 8'(r_wait_cnt + 8'd1);
          end
        end
        default: memReq <= 1'b0;
      endcase
    end
  end

endmodule
